// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared types and defaults for the lift scheduler
//
// Holds the scheduler state encoding, the committed-direction constants and
// the default geometry/timing parameters used by lift_scheduler.
package lift_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2,
    DOOR    = 2'd3
  } lift_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int DEF_N_FLOORS      = 8;
  localparam int DEF_TRAVEL_CYCLES = 16;
  localparam int DEF_DOOR_CYCLES   = 32;

endpackage

// File: rtl/lift_timer.sv
// rtl/lift_timer.sv - loadable down-counter shared by travel and door timing
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load        - load strobe; count takes load_val on the next edge
//   load_val    - value loaded into the counter
//   expired     - count has reached zero and no load is pending
module lift_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // A pending load masks the stale zero left over from the previous interval.
  assign expired = !load && (count == '0);

endmodule

// File: rtl/lift_scheduler.sv
// rtl/lift_scheduler.sv - collective (SCAN) lift scheduler with motor/door control
//
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   i_up_req_queue   - latched up-hall requests, bit i = floor i
//   i_dn_req_queue   - latched down-hall requests
//   i_flr_req_queue  - latched cabin requests
//   o_flr_pos        - cabin position, one-hot
//   o_up_clr/o_dn_clr/o_flr_clr - one-cycle retire pulses for the request at o_flr_pos
//   o_motor_up/o_motor_dn       - motor drive
//   o_door_open      - door open command
//   o_dir_up         - committed direction (1 = up)
module lift_scheduler
  import lift_pkg::*;
#(
  parameter int N_FLOORS      = DEF_N_FLOORS,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] i_up_req_queue,
  input  logic [N_FLOORS-1:0] i_dn_req_queue,
  input  logic [N_FLOORS-1:0] i_flr_req_queue,
  output logic [N_FLOORS-1:0] o_flr_pos,
  output logic                o_up_clr,
  output logic                o_dn_clr,
  output logic                o_flr_clr,
  output logic                o_motor_up,
  output logic                o_motor_dn,
  output logic                o_door_open,
  output logic                o_dir_up
);

  localparam int TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW      = $clog2(TMR_MAX);
  // The load strobe is registered, so the counter starts one cycle after the
  // FSM decides; loading N-2 makes expiry land exactly N edges later.
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 2);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 2);

  lift_state_t   state;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_exp;

  lift_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  logic [N_FLOORS-1:0] any_req, eval_pos, above_mask, below_mask;
  logic above, below, here_up, here_dn, here_flr;
  logic up_turn, up_stop, dn_turn, dn_stop, go_up, go_dn;

  // While moving, decisions are made on the floor being arrived at, so every
  // derived term is taken relative to the (saturating) shifted position.
  always_comb begin
    eval_pos = o_flr_pos;
    if (state == MOVE_UP && !o_flr_pos[N_FLOORS-1]) begin
      eval_pos = o_flr_pos << 1;
    end else if (state == MOVE_DN && !o_flr_pos[0]) begin
      eval_pos = o_flr_pos >> 1;
    end
  end

  assign any_req    = i_up_req_queue | i_dn_req_queue | i_flr_req_queue;
  assign below_mask = eval_pos - N_FLOORS'(1);
  assign above_mask = ~(below_mask | eval_pos);
  assign above      = |(any_req & above_mask);
  assign below      = |(any_req & below_mask);
  assign here_up    = |(i_up_req_queue & eval_pos);
  assign here_dn    = |(i_dn_req_queue & eval_pos);
  assign here_flr   = |(i_flr_req_queue & eval_pos);

  // An opposite-direction hall call is only taken when it is the end of the sweep.
  assign up_turn = here_dn & ~above;
  assign up_stop = here_flr | here_up | up_turn;
  assign dn_turn = here_up & ~below;
  assign dn_stop = here_flr | here_dn | dn_turn;

  // Leaving the door: keep the committed direction if work lies that way, else reverse.
  assign go_up = o_dir_up ? above : (above & ~below);
  assign go_dn = o_dir_up ? (below & ~above) : below;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      o_flr_pos   <= N_FLOORS'(1);
      o_dir_up    <= DIR_UP;
      o_up_clr    <= 1'b0;
      o_dn_clr    <= 1'b0;
      o_flr_clr   <= 1'b0;
      o_motor_up  <= 1'b0;
      o_motor_dn  <= 1'b0;
      o_door_open <= 1'b0;
      tmr_load    <= 1'b0;
      tmr_val     <= '0;
    end else begin
      o_up_clr  <= 1'b0;
      o_dn_clr  <= 1'b0;
      o_flr_clr <= 1'b0;
      tmr_load  <= 1'b0;
      case (state)
        IDLE: begin
          if (here_flr | here_up) begin
            state       <= DOOR;
            o_dir_up    <= DIR_UP;
            o_door_open <= 1'b1;
            o_flr_clr   <= here_flr;
            o_up_clr    <= here_up;
            tmr_load    <= 1'b1;
            tmr_val     <= DOOR_LOAD;
          end else if (here_dn) begin
            state       <= DOOR;
            o_dir_up    <= DIR_DN;
            o_door_open <= 1'b1;
            o_dn_clr    <= 1'b1;
            tmr_load    <= 1'b1;
            tmr_val     <= DOOR_LOAD;
          end else if (above) begin
            state      <= MOVE_UP;
            o_dir_up   <= DIR_UP;
            o_motor_up <= 1'b1;
            tmr_load   <= 1'b1;
            tmr_val    <= TRAVEL_LOAD;
          end else if (below) begin
            state      <= MOVE_DN;
            o_dir_up   <= DIR_DN;
            o_motor_dn <= 1'b1;
            tmr_load   <= 1'b1;
            tmr_val    <= TRAVEL_LOAD;
          end
        end
        MOVE_UP: begin
          if (tmr_exp) begin
            o_flr_pos <= eval_pos;
            if (up_stop) begin
              state       <= DOOR;
              o_motor_up  <= 1'b0;
              o_door_open <= 1'b1;
              o_flr_clr   <= here_flr;
              o_up_clr    <= here_up;
              o_dn_clr    <= up_turn;
              o_dir_up    <= up_turn ? DIR_DN : DIR_UP;
              tmr_load    <= 1'b1;
              tmr_val     <= DOOR_LOAD;
            end else if (above) begin
              tmr_load <= 1'b1;
              tmr_val  <= TRAVEL_LOAD;
            end else begin
              state      <= IDLE;
              o_motor_up <= 1'b0;
            end
          end
        end
        MOVE_DN: begin
          if (tmr_exp) begin
            o_flr_pos <= eval_pos;
            if (dn_stop) begin
              state       <= DOOR;
              o_motor_dn  <= 1'b0;
              o_door_open <= 1'b1;
              o_flr_clr   <= here_flr;
              o_dn_clr    <= here_dn;
              o_up_clr    <= dn_turn;
              o_dir_up    <= dn_turn ? DIR_UP : DIR_DN;
              tmr_load    <= 1'b1;
              tmr_val     <= DOOR_LOAD;
            end else if (below) begin
              tmr_load <= 1'b1;
              tmr_val  <= TRAVEL_LOAD;
            end else begin
              state      <= IDLE;
              o_motor_dn <= 1'b0;
            end
          end
        end
        DOOR: begin
          if (tmr_exp) begin
            if (here_flr | (o_dir_up ? here_up : here_dn)) begin
              // A request arrived at this floor while the door was open.
              o_flr_clr <= here_flr;
              o_up_clr  <= o_dir_up & here_up;
              o_dn_clr  <= ~o_dir_up & here_dn;
              tmr_load  <= 1'b1;
              tmr_val   <= DOOR_LOAD;
            end else begin
              o_door_open <= 1'b0;
              if (go_up) begin
                state      <= MOVE_UP;
                o_dir_up   <= DIR_UP;
                o_motor_up <= 1'b1;
                tmr_load   <= 1'b1;
                tmr_val    <= TRAVEL_LOAD;
              end else if (go_dn) begin
                state      <= MOVE_DN;
                o_dir_up   <= DIR_DN;
                o_motor_dn <= 1'b1;
                tmr_load   <= 1'b1;
                tmr_val    <= TRAVEL_LOAD;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lift_scheduler.sv
// tb/tb_lift_scheduler.sv - self-checking bench for lift_scheduler
module tb_lift_scheduler;

  localparam int NF = 8;
  localparam int TC = 4;
  localparam int DC = 6;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DN   = 2;
  localparam int M_DOOR = 3;

  logic          clk;
  logic          reset;
  logic [NF-1:0] up_q, dn_q, flr_q;
  logic [NF-1:0] flr_pos;
  logic          up_clr, dn_clr, flr_clr, motor_up, motor_dn, door_open, dir_up;

  int tests = 0;
  int fails = 0;
  bit check_en = 0;

  lift_scheduler #(
    .N_FLOORS      (NF),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_up_req_queue  (up_q),
    .i_dn_req_queue  (dn_q),
    .i_flr_req_queue (flr_q),
    .o_flr_pos       (flr_pos),
    .o_up_clr        (up_clr),
    .o_dn_clr        (dn_clr),
    .o_flr_clr       (flr_clr),
    .o_motor_up      (motor_up),
    .o_motor_dn      (motor_dn),
    .o_door_open     (door_open),
    .o_dir_up        (dir_up)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: integer floor, cycle counts measured from the edge
  // on which an activity starts.
  int m_floor = 0;
  int m_mode  = M_IDLE;
  int m_cnt   = 0;
  bit m_dir = 1, m_mu = 0, m_md = 0, m_door = 0, m_upc = 0, m_dnc = 0, m_flc = 0;

  function automatic bit qbit(logic [NF-1:0] v, int f);
    return v[f[2:0]];
  endfunction

  function automatic bit pend(int f);
    return qbit(up_q, f) | qbit(dn_q, f) | qbit(flr_q, f);
  endfunction

  function automatic bit any_above(int f);
    for (int i = f + 1; i < NF; i++) if (pend(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(int f);
    for (int i = 0; i < f; i++) if (pend(i)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic open_door(bit d, bit fc, bit uc, bit dc);
    m_mode = M_DOOR; m_cnt = 0; m_door = 1; m_dir = d;
    m_flc = fc; m_upc = uc; m_dnc = dc;
  endtask

  task automatic start_move(bit d);
    m_mode = d ? M_UP : M_DN; m_cnt = 0; m_dir = d; m_mu = d; m_md = !d;
  endtask

  task automatic model_step();
    bit up, ahead, along, against, turn, fwd, back;
    int f;
    m_upc = 0; m_dnc = 0; m_flc = 0;
    f = m_floor;
    case (m_mode)
      M_IDLE: begin
        if (qbit(flr_q, f) || qbit(up_q, f)) open_door(1'b1, qbit(flr_q, f), qbit(up_q, f), 1'b0);
        else if (qbit(dn_q, f)) open_door(1'b0, 1'b0, 1'b0, 1'b1);
        else if (any_above(f)) start_move(1'b1);
        else if (any_below(f)) start_move(1'b0);
      end
      M_UP, M_DN: begin
        m_cnt = m_cnt + 1;
        if (m_cnt == TC) begin
          up = (m_mode == M_UP);
          m_floor = up ? m_floor + 1 : m_floor - 1;
          f = m_floor;
          ahead   = up ? any_above(f) : any_below(f);
          along   = qbit(up ? up_q : dn_q, f);
          against = qbit(up ? dn_q : up_q, f);
          turn    = against && !ahead;
          if (qbit(flr_q, f) || along || turn) begin
            m_mu = 0; m_md = 0;
            open_door(up ^ turn, qbit(flr_q, f), up ? along : turn, up ? turn : along);
          end else if (ahead) begin
            m_cnt = 0;
          end else begin
            m_mode = M_IDLE; m_mu = 0; m_md = 0;
          end
        end
      end
      default: begin
        m_cnt = m_cnt + 1;
        if (m_cnt == DC) begin
          along = qbit(m_dir ? up_q : dn_q, f);
          if (qbit(flr_q, f) || along) begin
            m_cnt = 0;
            m_flc = qbit(flr_q, f);
            m_upc = m_dir && along;
            m_dnc = !m_dir && along;
          end else begin
            m_door = 0;
            fwd  = m_dir ? any_above(f) : any_below(f);
            back = m_dir ? any_below(f) : any_above(f);
            if (fwd) start_move(m_dir);
            else if (back) start_move(!m_dir);
            else m_mode = M_IDLE;
          end
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_floor = 0; m_mode = M_IDLE; m_cnt = 0; m_dir = 1;
      m_mu = 0; m_md = 0; m_door = 0; m_upc = 0; m_dnc = 0; m_flc = 0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [14:0] act, exp;
    if (check_en) begin
      act = {flr_pos, up_clr, dn_clr, flr_clr, motor_up, motor_dn, door_open, dir_up};
      exp = {8'd1 << m_floor, m_upc, m_dnc, m_flc, m_mu, m_md, m_door, m_dir};
      tests = tests + 1;
      if (act !== exp) begin
        fails = fails + 1;
        $display("FAIL model_cmp t=%0t {pos,upc,dnc,flc,mu,md,door,dir} got %h expected %h",
                 $time, act, exp);
      end
    end
  end

  task automatic chk1(string name, logic act, logic exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle; the bench then retires any request whose clear was pulsed.
  task automatic tick();
    @(negedge clk);
    if (flr_clr) flr_q = flr_q & ~flr_pos;
    if (up_clr)  up_q  = up_q  & ~flr_pos;
    if (dn_clr)  dn_q  = dn_q  & ~flr_pos;
  endtask

  task automatic reset_dut();
    up_q = '0; dn_q = '0; flr_q = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    up_q = '0; dn_q = '0; flr_q = '0;
    tick();
    chk8("rst_pos", flr_pos, 8'h01);
    chk1("rst_dir", dir_up, 1'b1);
    chk8("rst_others", {1'b0, up_clr, dn_clr, flr_clr, motor_up, motor_dn, door_open, 1'b0}, 8'h00);
    check_en = 1;
    reset = 1'b0;

    // Single cabin request to floor 3.
    flr_q = 8'h08;
    tick();
    chk1("single_motor_rise", motor_up, 1'b1);
    repeat (3) tick();
    chk8("single_pos_t4", flr_pos, 8'h01);
    tick();
    chk8("single_pos_t5", flr_pos, 8'h02);
    repeat (4) tick();
    chk8("single_pos_t9", flr_pos, 8'h04);
    repeat (4) tick();
    chk8("single_pos_t13", flr_pos, 8'h08);
    chk1("single_flr_clr", flr_clr, 1'b1);
    chk1("single_door_rise", door_open, 1'b1);
    chk1("single_motor_off", motor_up, 1'b0);
    tick();
    chk1("single_clr_one_cycle", flr_clr, 1'b0);
    repeat (4) tick();
    chk1("single_door_last", door_open, 1'b1);
    tick();
    chk1("single_door_closed", door_open, 1'b0);
    repeat (2) tick();

    // Collective sweep.
    reset_dut();
    up_q = 8'h04; dn_q = 8'h08; flr_q = 8'h20;
    repeat (9) tick();
    chk8("sweep_stop2_pos", flr_pos, 8'h04);
    chk1("sweep_stop2_upclr", up_clr, 1'b1);
    chk1("sweep_stop2_dnclr", dn_clr, 1'b0);
    repeat (10) tick();
    chk8("sweep_pass3_pos", flr_pos, 8'h08);
    chk1("sweep_pass3_motor", motor_up, 1'b1);
    chk1("sweep_pass3_nodoor", door_open, 1'b0);
    repeat (8) tick();
    chk8("sweep_stop5_pos", flr_pos, 8'h20);
    chk1("sweep_stop5_flrclr", flr_clr, 1'b1);
    repeat (14) tick();
    chk8("sweep_stop3_pos", flr_pos, 8'h08);
    chk1("sweep_stop3_dnclr", dn_clr, 1'b1);
    chk1("sweep_stop3_dir", dir_up, 1'b0);
    repeat (7) tick();
    chk1("sweep_idle_door", door_open, 1'b0);
    chk1("sweep_idle_motor", motor_dn, 1'b0);

    // Turnaround at the top of the sweep.
    reset_dut();
    dn_q = 8'h40;
    repeat (24) tick();
    chk8("turn_pos_t24", flr_pos, 8'h20);
    tick();
    chk8("turn_pos", flr_pos, 8'h40);
    chk1("turn_dnclr", dn_clr, 1'b1);
    chk1("turn_upclr", up_clr, 1'b0);
    chk1("turn_flrclr", flr_clr, 1'b0);
    chk1("turn_dir", dir_up, 1'b0);
    repeat (6) tick();
    chk1("turn_door_closed", door_open, 1'b0);

    // Door re-open.
    reset_dut();
    flr_q = 8'h04;
    repeat (9) tick();
    chk1("reopen_first_clr", flr_clr, 1'b1);
    repeat (2) tick();
    flr_q = flr_q | 8'h04;
    repeat (4) tick();
    chk1("reopen_second_clr", flr_clr, 1'b1);
    chk1("reopen_door_held", door_open, 1'b1);
    repeat (5) tick();
    chk1("reopen_door_late", door_open, 1'b1);
    tick();
    chk1("reopen_door_closed", door_open, 1'b0);

    // Reset while moving.
    reset_dut();
    flr_q = 8'h80;
    repeat (10) tick();
    chk8("midrst_pre_pos", flr_pos, 8'h04);
    chk1("midrst_pre_motor", motor_up, 1'b1);
    reset = 1'b1;
    flr_q = '0;
    tick();
    chk8("midrst_pos", flr_pos, 8'h01);
    chk8("midrst_outs", {1'b0, up_clr, dn_clr, flr_clr, motor_up, motor_dn, door_open, 1'b0}, 8'h00);
    reset = 1'b0;
    repeat (3) tick();
    chk1("midrst_idle_motor", motor_up, 1'b0);

    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
